// File: rtl/oversample_filter.sv
// Oversampling averager: sums 2^os signed ADC samples and emits the arithmetic-shifted mean.
// Latency 1 cycle from the window's last accepted sample to data_valid_out.
// No backpressure: every data_valid_in pulse is consumed, except on a clear_in cycle, where it is dropped.
// Optional feature macro OSF_ROUNDING_EN: round half toward +inf instead of truncating.
module oversample_filter #(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 18,
  parameter int W_EP    = 16,
  parameter int MAX_OS  = 10,
  parameter int OS_INIT = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_IN-1:0]   data_in,
  input  logic              data_valid_in,
  input  logic [W_EP-1:0]   os_in,
  input  logic              clear_in,
  input  logic              update_en_in,
  input  logic              update_in,
  output logic [W_OUT-1:0]  data_out,
  output logic              data_valid_out
);

  // The accumulator holds up to 2^MAX_OS full-scale samples without overflow.
  // The sum carries one extra bit so that the rounding offset cannot wrap.
  localparam int W_ACC  = W_IN + MAX_OS;
  localparam int W_SUM  = W_ACC + 1;
  localparam int W_WIDE = ((W_SUM > W_OUT) ? W_SUM : W_OUT) + 1;
  localparam int OS_W   = (MAX_OS < 1) ? 1 : $clog2(MAX_OS + 1);
  localparam int CNT_W  = MAX_OS + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t                   state, state_nx;
  logic signed [W_ACC-1:0]  acc, acc_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic [OS_W-1:0]          os, os_nx;
  logic [OS_W-1:0]          pend, pend_nx;
  logic [W_OUT-1:0]         dout_nx;

  logic [OS_W-1:0]          os_req;
  logic signed [W_SUM-1:0]  base_acc;
  logic signed [W_SUM-1:0]  sum;
  logic signed [W_SUM-1:0]  sum_rnd;
  logic signed [W_WIDE-1:0] wide;
  logic signed [W_WIDE-1:0] shifted;
  logic [CNT_W-1:0]         base_cnt;
  logic [CNT_W-1:0]         cnt_inc;
  logic [CNT_W-1:0]         n_target;
  logic                     take;
  logic                     done;
  logic                     boundary;

  // Requested ratio, saturated to the largest supported value.
  always_comb begin
    os_req = os_in[OS_W-1:0];
    if (os_in > W_EP'(MAX_OS)) begin
      os_req = OS_W'(MAX_OS);
    end
  end

  // Next-state and datapath: accumulate, close the window, apply ratio changes at boundaries.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    os_nx    = os;
    dout_nx  = data_out;
    pend_nx  = pend;

    if (update_en_in && update_in) begin
      pend_nx = os_req;
    end

    // A sample arriving in ST_SEND starts a fresh window, so treat the running sum as empty.
    base_acc = (state == ST_SEND) ? '0 : {acc[W_ACC-1], acc};
    base_cnt = (state == ST_SEND) ? '0 : cnt;

    sum      = base_acc + {{(W_SUM-W_IN){data_in[W_IN-1]}}, data_in};
    cnt_inc  = base_cnt + CNT_W'(1);
    n_target = CNT_W'(1) << os;

    sum_rnd = sum;
`ifdef OSF_ROUNDING_EN
    if (os != '0) begin
      sum_rnd = sum + (W_SUM'(1) << (os - OS_W'(1)));
    end
`endif

    wide    = {{(W_WIDE-W_SUM){sum_rnd[W_SUM-1]}}, sum_rnd};
    shifted = wide >>> os;

    take = data_valid_in && !clear_in;
    done = take && (cnt_inc == n_target);

    // The ratio may only change when no partial window exists after this edge.
    boundary = clear_in || done || (!take && (base_cnt == '0));

    if (clear_in) begin
      acc_nx   = '0;
      cnt_nx   = '0;
      state_nx = ST_ACCUM;
    end else if (take) begin
      if (done) begin
        acc_nx   = '0;
        cnt_nx   = '0;
        state_nx = ST_SEND;
        dout_nx  = shifted[W_OUT-1:0];
      end else begin
        acc_nx   = sum[W_ACC-1:0];
        cnt_nx   = cnt_inc;
        state_nx = ST_ACCUM;
      end
    end else begin
      state_nx = ST_ACCUM;
    end

    if (boundary) begin
      os_nx = pend_nx;
    end
  end

  // State, accumulator, ratio and output registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      cnt      <= '0;
      os       <= OS_W'(OS_INIT);
      pend     <= OS_W'(OS_INIT);
      data_out <= '0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      os       <= os_nx;
      pend     <= pend_nx;
      data_out <= dout_nx;
    end
  end

  assign data_valid_out = (state == ST_SEND);

endmodule

// File: tb/tb_oversample_filter.sv
// Testbench for oversample_filter: vector table plus hand-written corner sequences.
// Expected averages are queued with their strobe cycle and checked when data_valid_out fires.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_oversample_filter;

  localparam int W_IN   = 16;
  localparam int W_OUT  = 18;
  localparam int W_EP   = 16;
  localparam int MAX_OS = 10;

  logic              clk_in;
  logic              reset_in;
  logic [W_IN-1:0]   data_in;
  logic              data_valid_in;
  logic [W_EP-1:0]   os_in;
  logic              clear_in;
  logic              update_en_in;
  logic              update_in;
  logic [W_OUT-1:0]  data_out;
  logic              data_valid_out;

  oversample_filter #(
    .W_IN(W_IN), .W_OUT(W_OUT), .W_EP(W_EP), .MAX_OS(MAX_OS), .OS_INIT(0)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .data_in(data_in),
    .data_valid_in(data_valid_in),
    .os_in(os_in),
    .clear_in(clear_in),
    .update_en_in(update_en_in),
    .update_in(update_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out)
  );

  typedef struct {
    int os;
    int base;
    int step;
    int exp_t;
    int exp_r;
  } vec_t;

  typedef struct {
    int     val;
    longint cyc;
  } sb_t;

  sb_t    sbq[$];
  sb_t    e_mon;
  vec_t   vecs[8];
  longint cyc;
  int     checks;
  int     passes;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic int pick(input int t, input int r);
`ifdef OSF_ROUNDING_EN
    return r;
`else
    return t;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_os(input int v, input bit en);
    os_in        = W_EP'(v);
    update_en_in = en;
    update_in    = 1'b1;
    tick();
    update_in    = 1'b0;
    update_en_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic send(input int s, input bit last, input int e);
    data_in       = W_IN'(s);
    data_valid_in = 1'b1;
    if (last) sbq.push_back('{val: e, cyc: cyc + 1});
    tick();
    data_valid_in = 1'b0;
  endtask

  // Every strobe must match the oldest queued expectation, value and cycle.
  always @(negedge clk_in) begin
    if (!reset_in && data_valid_out) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d data_out %0d, expected none",
                 cyc, $signed(data_out));
      end else begin
        e_mon = sbq.pop_front();
        check("strobe_data_out", $signed(data_out), e_mon.val);
        check("strobe_cycle", cyc, e_mon.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wait_cnt;
    checks        = 0;
    passes        = 0;
    reset_in      = 1'b1;
    data_in       = '0;
    data_valid_in = 1'b0;
    os_in         = '0;
    clear_in      = 1'b0;
    update_en_in  = 1'b0;
    update_in     = 1'b0;

    vecs[0] = '{os: 2,  base: 10,     step: 1,  exp_t: 11,     exp_r: 12};
    vecs[1] = '{os: 0,  base: -32768, step: 0,  exp_t: -32768, exp_r: -32768};
    vecs[2] = '{os: 0,  base: 32767,  step: 0,  exp_t: 32767,  exp_r: 32767};
    vecs[3] = '{os: 10, base: -1,     step: 0,  exp_t: -1,     exp_r: -1};
    vecs[4] = '{os: 1,  base: -3,     step: 1,  exp_t: -3,     exp_r: -2};
    vecs[5] = '{os: 3,  base: 100,    step: -7, exp_t: 75,     exp_r: 76};
    vecs[6] = '{os: 2,  base: 32767,  step: 0,  exp_t: 32767,  exp_r: 32767};
    vecs[7] = '{os: 2,  base: -32768, step: 0,  exp_t: -32768, exp_r: -32768};

    tick();
    tick();
    check("reset_data_out", data_out, 0);
    check("reset_data_valid_out", data_valid_out, 0);
    reset_in = 1'b0;
    tick();

    // Back-to-back samples at os = 0: two strobes on consecutive cycles.
    set_os(0, 1'b1);
    send(-32768, 1'b1, -32768);
    send(32767, 1'b1, 32767);
    tick();
    tick();

    for (int v = 0; v < 8; v++) begin
      set_os(vecs[v].os, 1'b1);
      n = 1 << vecs[v].os;
      for (int i = 0; i < n; i++) begin
        send(vecs[v].base + i * vecs[v].step, (i == n - 1), pick(vecs[v].exp_t, vecs[v].exp_r));
      end
      tick();
      tick();
    end

    // update_in without update_en_in is ignored: the window stays at 4 samples.
    set_os(0, 1'b0);
    send(2, 1'b0, 0);
    send(2, 1'b0, 0);
    send(2, 1'b0, 0);
    send(6, 1'b1, 3);
    tick();
    tick();

    // A ratio change mid-window waits for the window to close.
    set_os(3, 1'b1);
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    set_os(1, 1'b1);
    for (int i = 3; i <= 8; i++) send(i, (i == 8), pick(4, 5));
    send(20, 1'b0, 0);
    send(22, 1'b1, 21);
    send(30, 1'b0, 0);
    send(31, 1'b1, pick(30, 31));
    for (int i = 0; i < 5; i++) tick();
    check("data_out_hold", $signed(data_out), pick(30, 31));

    // clear_in together with the 3rd sample drops the window and leaves data_out alone.
    set_os(2, 1'b1);
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    data_in       = W_IN'(3);
    data_valid_in = 1'b1;
    clear_in      = 1'b1;
    tick();
    data_valid_in = 1'b0;
    clear_in      = 1'b0;
    tick();
    check("clear_keeps_data_out", $signed(data_out), pick(30, 31));
    for (int i = 0; i < 4; i++) send(4, (i == 3), 4);
    tick();
    tick();

    // Asynchronous reset mid-window, then a saturating ratio request.
    send(9, 1'b0, 0);
    send(9, 1'b0, 0);
    #2;
    reset_in = 1'b1;
    #1;
    check("async_reset_data_out", data_out, 0);
    check("async_reset_data_valid_out", data_valid_out, 0);
    reset_in = 1'b0;
    tick();
    set_os(99, 1'b1);
    for (int i = 0; i < 1024; i++) send(5, (i == 1023), 5);

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    tick();
    check("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/oversample_filter.md
OVERSAMPLE_FILTER -- requirements
Module: oversample_filter

Interface
REQ-001 SHALL have parameter W_IN, default 16: signed ADC sample width.
REQ-002 SHALL have parameter W_OUT, default 18: signed output width, W_OUT >= W_IN.
REQ-003 SHALL have parameter W_EP, default 16: frontpanel endpoint width.
REQ-004 SHALL have parameter MAX_OS, default 10: maximum log2 oversample ratio.
REQ-005 SHALL have parameter OS_INIT, default 0: log2 ratio after reset.
REQ-006 SHALL have port clk_in, input, 1: system clock; the block uses one clock; all logic samples on its rising edge.
REQ-007 SHALL have port reset_in, input, 1: system reset, asynchronous and active-high.
REQ-008 SHALL have port data_in, input, W_IN: signed ADC sample.
REQ-009 SHALL have port data_valid_in, input, 1: data_in valid, single-cycle pulse per sample.
REQ-010 SHALL have port os_in, input, W_EP: requested log2 oversample ratio (unsigned).
REQ-011 SHALL have port clear_in, input, 1: discard the partial window.
REQ-012 SHALL have port update_en_in, input, 1: enables sensitivity to update_in.
REQ-013 SHALL have port update_in, input, 1: pulse requesting a load of os_in.
REQ-014 SHALL have port data_out, output, W_OUT: signed window average, registered.
REQ-015 SHALL have port data_valid_out, output, 1: one-cycle strobe marking data_out valid for the PID stage.

Function
REQ-016 SHALL average N = 2^os consecutive accepted samples, where os is the active ratio register.
REQ-017 SHALL hold the accumulator as a signed value W_IN+MAX_OS bits wide, so it never overflows.
REQ-018 SHALL produce data_out as the accumulator arithmetically shifted right by os, then sign-extended to W_OUT.
REQ-019 SHALL implement two states: ST_ACCUM (collect samples) and ST_SEND (present result).
REQ-020 In ST_ACCUM, SHALL add each valid sample to the accumulator and increment the sample counter.
REQ-021 SHALL transition from ST_ACCUM to ST_SEND on the valid sample that makes the count equal N.
REQ-022 On that transition, SHALL register the result into data_out.
REQ-023 SHALL assert data_valid_out for exactly one cycle in ST_SEND, then return to ST_ACCUM.
REQ-024 SHALL assert data_valid_out on the cycle after the window's last sample is accepted (latency 1).
REQ-025 SHALL accept a valid sample arriving in ST_SEND as the first sample of the next window: accumulator = sample, count = 1.
REQ-026 SHALL hold data_out stable between strobes.
REQ-027 With os = 0, SHALL emit every sample unchanged (sign-extended) with latency 1.
REQ-028 SHALL capture os_in into a pending register when update_in = 1 and update_en_in = 1, saturating values above MAX_OS to MAX_OS.
REQ-029 SHALL apply the pending ratio to os only at a window boundary: the transition into ST_SEND, or while count = 0.
REQ-030 SHALL NOT apply a new ratio mid-window.
REQ-031 On clear_in = 1, SHALL zero the accumulator and count and return to ST_ACCUM.
REQ-032 clear_in SHALL take priority over a simultaneous valid sample, which is dropped.
REQ-033 clear_in SHALL leave data_out unchanged.
REQ-034 clear_in SHALL suppress a pending data_valid_out strobe only if it coincides with ST_ACCUM.
REQ-035 An update coinciding with clear_in SHALL be applied immediately, because count is then 0.

Reset
REQ-036 On reset_in = 1, asynchronously: state = ST_ACCUM, accumulator = 0, count = 0, data_out = 0, data_valid_out = 0, os = pending = OS_INIT.
REQ-037 Reset mid-window SHALL discard all partial data; no strobe SHALL follow deassertion until a full new window is accepted.

Configuration
REQ-038 SHALL honour macro OSF_ROUNDING_EN.
REQ-039 When OSF_ROUNDING_EN is defined, SHALL add 2^(os-1) to the sum before the shift when os > 0 (round half toward +infinity).
REQ-040 When OSF_ROUNDING_EN is undefined, SHALL truncate the sum toward -infinity with no added offset.

Verification
REQ-041 SHALL verify: os = 2 (via update), samples 10, 11, 12, 13 -> one strobe the cycle after the 4th sample, data_out = 11 (truncating) or 12 (OSF_ROUNDING_EN).
REQ-042 SHALL verify: os = 0, samples -32768, 32767 on consecutive cycles -> two strobes, data_out = -32768 then 32767 sign-extended to 18 bits.
REQ-043 SHALL verify: os = 10, 1024 samples of -1 -> single strobe, data_out = -1; the accumulator reaches -1024 without overflow.
REQ-044 SHALL verify: os = 3, update to os = 1 after the 2nd sample -> the first window still uses 8 samples; following windows use 2 samples.
REQ-045 SHALL verify: os = 2, clear_in coincident with the 3rd sample -> no strobe; the next 4 samples 4, 4, 4, 4 yield data_out = 4.
REQ-046 SHALL verify: reset_in pulsed asynchronously between clock edges mid-window -> outputs zero immediately; os_in = 99 with update then gives os = MAX_OS.
